// File: rtl/vending_fsm_param.sv
// Parametrised coin vending controller: edge-detected 1/2/5-unit coins, vend at PRICE,
// change or cancel refund paid out serially as 2-unit then 1-unit return pulses.
module vending_fsm_param #(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                one,
  input  logic                two,
  input  logic                five,
  input  logic                cancel,
  output logic                d,
  output logic [CREDIT_W-1:0] r,
  output logic                ret_one,
  output logic                ret_two,
  output logic                busy,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {COLLECT, VEND, PAYOUT} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO_C   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] remaining, remaining_nx, credit_nx, r_nx;
  logic [CREDIT_W-1:0] coin_val, sum;
  logic                d_nx, ret_one_nx, ret_two_nx, coin_rej_nx;
  logic                one_q, two_q, five_q;
  logic                one_e, two_e, five_e;
  logic [1:0]          n_edges;
  logic                any_coin, multi_coin, eff_cancel;

  assign one_e   = one  & ~one_q;
  assign two_e   = two  & ~two_q;
  assign five_e  = five & ~five_q;
  assign n_edges = {1'b0, one_e} + {1'b0, two_e} + {1'b0, five_e};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx     = state;
    credit_nx    = credit;
    remaining_nx = remaining;
    r_nx         = r;
    d_nx         = 1'b0;
    ret_one_nx   = 1'b0;
    ret_two_nx   = 1'b0;
    coin_val     = '0;
    if (one_e)  coin_val = ONE_C;
    if (two_e)  coin_val = TWO_C;
    if (five_e) coin_val = FIVE_C;
    sum        = credit + coin_val;
    any_coin   = (n_edges != 2'd0);
    multi_coin = (n_edges > 2'd1);
    eff_cancel = cancel && (state == COLLECT) && (credit != '0);
    coin_rej_nx = any_coin && (multi_coin || (state != COLLECT) || eff_cancel);

    case (state)
      COLLECT: begin
        if (eff_cancel) begin
          // Refund starts paying out immediately, so the first coin leaves this edge.
          state_nx  = PAYOUT;
          r_nx      = credit;
          credit_nx = '0;
          if (credit >= TWO_C) begin
            ret_two_nx   = 1'b1;
            remaining_nx = credit - TWO_C;
          end else begin
            ret_one_nx   = 1'b1;
            remaining_nx = credit - ONE_C;
          end
        end else if (any_coin && !multi_coin) begin
          if (sum < PRICE_C) begin
            credit_nx = sum;
          end else begin
            state_nx     = VEND;
            d_nx         = 1'b1;
            r_nx         = sum - PRICE_C;
            credit_nx    = '0;
            remaining_nx = sum - PRICE_C;
          end
        end
      end
      VEND, PAYOUT: begin
        if (remaining >= TWO_C) begin
          state_nx     = PAYOUT;
          ret_two_nx   = 1'b1;
          remaining_nx = remaining - TWO_C;
        end else if (remaining == ONE_C) begin
          state_nx     = PAYOUT;
          ret_one_nx   = 1'b1;
          remaining_nx = '0;
        end else begin
          state_nx = COLLECT;
          r_nx     = '0;
        end
      end
      default: state_nx = COLLECT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      credit    <= '0;
      remaining <= '0;
      r         <= '0;
      d         <= 1'b0;
      ret_one   <= 1'b0;
      ret_two   <= 1'b0;
      busy      <= 1'b0;
      coin_rej  <= 1'b0;
      // Preset high so a coin level already present at reset release is not counted.
      one_q     <= 1'b1;
      two_q     <= 1'b1;
      five_q    <= 1'b1;
    end else begin
      state     <= state_nx;
      credit    <= credit_nx;
      remaining <= remaining_nx;
      r         <= r_nx;
      d         <= d_nx;
      ret_one   <= ret_one_nx;
      ret_two   <= ret_two_nx;
      busy      <= (state_nx != COLLECT);
      coin_rej  <= coin_rej_nx;
      one_q     <= one;
      two_q     <= two;
      five_q    <= five;
    end
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param: PRICE=5 and PRICE=7 instances share one stimulus stream.
module tb_vending_fsm_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic one = 1'b0, two = 1'b0, five = 1'b0, cancel = 1'b0;

  logic       d5, ro5, rt5, busy5, rej5;
  logic [3:0] r5, cr5;
  logic       d7, ro7, rt7, busy7, rej7;
  logic [3:0] r7, cr7;

  int n_vec = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  vending_fsm_param #(.PRICE(5), .CREDIT_W(4)) dut5 (
    .clk(clk), .reset(reset), .one(one), .two(two), .five(five), .cancel(cancel),
    .d(d5), .r(r5), .ret_one(ro5), .ret_two(rt5), .busy(busy5), .coin_rej(rej5), .credit(cr5)
  );

  vending_fsm_param #(.PRICE(7), .CREDIT_W(4)) dut7 (
    .clk(clk), .reset(reset), .one(one), .two(two), .five(five), .cancel(cancel),
    .d(d7), .r(r7), .ret_one(ro7), .ret_two(rt7), .busy(busy7), .coin_rej(rej7), .credit(cr7)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive inputs, let one posedge sample them, then settle 1 time unit before checking.
  task automatic cyc(input logic o, input logic t, input logic f, input logic c);
    one = o; two = t; five = f; cancel = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_d", d5, 0);       check("rst_r", r5, 0);
    check("rst_ret_one", ro5, 0); check("rst_ret_two", rt5, 0);
    check("rst_busy", busy5, 0); check("rst_rej", rej5, 0);
    check("rst_credit", cr5, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0);

    // 1,2,2 -> exact vend
    cyc(1, 0, 0, 0); check("t1_cr1", cr5, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("t1_cr3", cr5, 3);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("t1_d", d5, 1); check("t1_r", r5, 0);
                     check("t1_busy", busy5, 1); check("t1_cr0", cr5, 0);
    cyc(0, 0, 0, 0); check("t1_d_off", d5, 0); check("t1_busy_off", busy5, 0);
                     check("t1_no_rt", rt5, 0); check("t1_no_ro", ro5, 0);

    // 2,2,5 -> change 4 as two ret_two pulses
    cyc(0, 1, 0, 0); check("t2_cr2", cr5, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("t2_cr4", cr5, 4);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); check("t2_d", d5, 1); check("t2_r", r5, 4);
                     check("t2_busy1", busy5, 1); check("t2_cr0", cr5, 0);
    cyc(0, 0, 0, 0); check("t2_rt1", rt5, 1); check("t2_d_off", d5, 0);
                     check("t2_r_hold", r5, 4); check("t2_busy2", busy5, 1);
    cyc(0, 0, 0, 0); check("t2_rt2", rt5, 1); check("t2_busy3", busy5, 1); check("t2_ro", ro5, 0);
    cyc(0, 0, 0, 0); check("t2_busy_off", busy5, 0); check("t2_rt_off", rt5, 0);
                     check("t2_r_clr", r5, 0); check("t2_cr_end", cr5, 0);

    // 2,2,2 -> change 1; then 2 + cancel -> refund 2
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("t3_d", d5, 1); check("t3_r", r5, 1);
    cyc(0, 0, 0, 0); check("t3_ro", ro5, 1); check("t3_rt", rt5, 0); check("t3_busy", busy5, 1);
    cyc(0, 0, 0, 0); check("t3_busy_off", busy5, 0); check("t3_ro_off", ro5, 0); check("t3_r_clr", r5, 0);
    cyc(0, 1, 0, 0); check("t3_cr2", cr5, 2);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); check("t3_cx_busy", busy5, 1); check("t3_cx_r", r5, 2);
                     check("t3_cx_d", d5, 0); check("t3_cx_rt", rt5, 1); check("t3_cx_cr", cr5, 0);
    cyc(0, 0, 0, 0); check("t3_cx_done", busy5, 0); check("t3_cx_rt_off", rt5, 0);
                     check("t3_cx_r_clr", r5, 0);

    // simultaneous coins rejected
    cyc(1, 1, 0, 0); check("rej_multi", rej5, 1); check("rej_multi_cr", cr5, 0);
    cyc(0, 0, 0, 0); check("rej_multi_off", rej5, 0); check("rej_multi_cr2", cr5, 0);

    // coin during payout rejected
    cyc(0, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); check("rej_pay_d", d5, 1);
    cyc(0, 0, 0, 0); check("rej_pay_rt1", rt5, 1);
    cyc(0, 1, 0, 0); check("rej_busy", rej5, 1); check("rej_pay_rt2", rt5, 1);
    cyc(0, 0, 0, 0); check("rej_busy_off", rej5, 0); check("rej_pay_idle", busy5, 0);
                     check("rej_pay_cr", cr5, 0);

    // five held 4 cycles -> one vend
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0);
      cnt += int'(d5);
    end
    check("hold_once", cnt, 1); check("hold_cr", cr5, 0);
    cyc(0, 0, 0, 0);

    // five high across reset release -> not counted until it re-rises
    reset = 1'b1;
    cyc(0, 0, 1, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1, 0);
      cnt += int'(d5) + int'(cr5);
    end
    check("rst_hold_ignored", cnt, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); check("rst_hold_rerise", d5, 1);
    cyc(0, 0, 0, 0);

    // cancel with no credit
    cyc(0, 0, 0, 1); check("cx0_busy", busy5, 0); check("cx0_pulses", int'(rt5) + int'(ro5), 0);
                     check("cx0_r", r5, 0);
    cyc(0, 0, 0, 0);

    // cancel and coin together with credit 3
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); check("cxc_cr3", cr5, 3);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1); check("cxc_rej", rej5, 1); check("cxc_r", r5, 3);
                     check("cxc_rt", rt5, 1); check("cxc_busy", busy5, 1); check("cxc_cr", cr5, 0);
    cyc(0, 0, 0, 0); check("cxc_ro", ro5, 1); check("cxc_rt_off", rt5, 0);
                     check("cxc_rej_off", rej5, 0); check("cxc_busy2", busy5, 1);
    cyc(0, 0, 0, 0); check("cxc_done", busy5, 0); check("cxc_r_clr", r5, 0);

    // PRICE=7: 5,5 -> change 3 as ret_two then ret_one
    do_reset();
    cyc(0, 0, 1, 0); check("p7_cr5", cr7, 5);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); check("p7_d", d7, 1); check("p7_r", r7, 3);
                     check("p7_busy", busy7, 1); check("p7_cr0", cr7, 0);
    cyc(0, 0, 0, 0); check("p7_rt", rt7, 1); check("p7_r_hold", r7, 3);
    cyc(0, 0, 0, 0); check("p7_ro", ro7, 1); check("p7_rt_off", rt7, 0); check("p7_busy3", busy7, 1);
    cyc(0, 0, 0, 0); check("p7_done", busy7, 0); check("p7_r_clr", r7, 0); check("p7_ro_off", ro7, 0);

    // same again, reset during the ret_two cycle aborts payout
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0); check("p7a_d", d7, 1);
    cyc(0, 0, 0, 0); check("p7a_rt", rt7, 1);
    reset = 1'b1;
    cyc(0, 0, 0, 0);
    check("p7a_d0", d7, 0); check("p7a_r0", r7, 0); check("p7a_ro0", ro7, 0);
    check("p7a_rt0", rt7, 0); check("p7a_busy0", busy7, 0); check("p7a_cr0", cr7, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0); check("p7a_no_ro", ro7, 0); check("p7a_idle", busy7, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
